// File: rtl/sha_acc_sequencer.sv
// rtl/sha_acc_sequencer.sv - sequences one SHA-256 job: register config fetch, memory word fetch, core streaming, status.
module sha_acc_sequencer #(
  parameter int          WORDS_PER_BLOCK = 16,
  parameter int          CNT_W           = 16,
  parameter logic [31:0] REG_BASE        = 32'h2000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  output logic        reg_req_o,
  output logic [31:0] reg_addr_o,
  input  logic        reg_gnt_i,
  input  logic [31:0] reg_rdata_i,
  output logic        status_we_o,
  output logic [31:0] status_wdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        core_init_o,
  output logic        core_next_o,
  output logic        core_valid_o,
  output logic [31:0] core_word_o,
  input  logic        core_ready_i,
  input  logic        core_done_i,
  output logic        busy_o
);

  localparam int WI_W = $clog2(WORDS_PER_BLOCK) + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SRC, S_RD_LEN, S_BLK_START, S_FETCH,
    S_WAIT_R, S_PUSH, S_WAIT_CORE, S_DONE, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic [CNT_W-1:0] blk_idx_q, blk_idx_d;
  logic [WI_W-1:0]  word_idx_q, word_idx_d;
  logic             abort_pend_q, abort_pend_d;
  logic [31:0]      word_q, word_d;

  logic             reg_req_q, reg_req_d;
  logic [31:0]      reg_addr_q, reg_addr_d;
  logic             status_we_q, status_we_d;
  logic [31:0]      status_wdata_q, status_wdata_d;
  logic             mem_req_q, mem_req_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             core_init_q, core_init_d;
  logic             core_next_q, core_next_d;
  logic             core_valid_q, core_valid_d;
  logic             busy_q, busy_d;
  logic [31:0]      word_off;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    blocks_d     = blocks_q;
    blk_idx_d    = blk_idx_q;
    word_idx_d   = word_idx_q;
    abort_pend_d = abort_pend_q;
    word_d       = word_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d      = S_RD_SRC;
          blk_idx_d    = '0;
          word_idx_d   = '0;
          abort_pend_d = 1'b0;
        end
      end
      S_RD_SRC: begin
        if (abort_i) begin
          state_d = S_ERR;
        end else if (reg_gnt_i) begin
          src_d   = reg_rdata_i;
          state_d = (reg_rdata_i[1:0] != 2'b00) ? S_ERR : S_RD_LEN;
        end
      end
      S_RD_LEN: begin
        if (abort_i) begin
          state_d = S_ERR;
        end else if (reg_gnt_i) begin
          blocks_d = reg_rdata_i[CNT_W-1:0];
          state_d  = (reg_rdata_i[CNT_W-1:0] == '0) ? S_DONE : S_BLK_START;
        end
      end
      S_BLK_START: begin
        word_idx_d = '0;
        state_d    = abort_i ? S_ERR : S_FETCH;
      end
      S_FETCH: begin
        // A granted read always has a response coming, so an abort in the grant cycle is deferred.
        if (mem_gnt_i) begin
          state_d      = S_WAIT_R;
          abort_pend_d = abort_i;
        end else if (abort_i) begin
          state_d = S_ERR;
        end
      end
      S_WAIT_R: begin
        if (abort_i) abort_pend_d = 1'b1;
        if (mem_rvalid_i) begin
          if (mem_err_i || abort_pend_d) begin
            state_d = S_ERR;
          end else begin
            word_d  = mem_rdata_i;
            state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        if (abort_i) begin
          state_d = S_ERR;
        end else if (core_ready_i) begin
          word_idx_d = word_idx_q + 1'b1;
          state_d    = (word_idx_d == WI_W'(WORDS_PER_BLOCK)) ? S_WAIT_CORE : S_FETCH;
        end
      end
      S_WAIT_CORE: begin
        if (abort_i) begin
          state_d = S_ERR;
        end else if (core_done_i) begin
          blk_idx_d = blk_idx_q + 1'b1;
          state_d   = (blk_idx_d == blocks_q) ? S_DONE : S_BLK_START;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    word_off       = 32'(blk_idx_d) * 32'(WORDS_PER_BLOCK) + 32'(word_idx_d);
    reg_req_d      = (state_d == S_RD_SRC) || (state_d == S_RD_LEN);
    reg_addr_d     = (state_d == S_RD_SRC) ? REG_BASE :
                     (state_d == S_RD_LEN) ? REG_BASE + 32'd4 : 32'd0;
    mem_req_d      = (state_d == S_FETCH);
    mem_addr_d     = (state_d == S_FETCH) ? src_d + (word_off << 2) : 32'd0;
    core_init_d    = (state_d == S_BLK_START) && (blk_idx_d == '0);
    core_next_d    = (state_d == S_BLK_START) && (blk_idx_d != '0);
    core_valid_d   = (state_d == S_PUSH);
    busy_d         = (state_d != S_IDLE);
    status_we_d    = ((state_d == S_RD_SRC) && (state_q == S_IDLE)) ||
                     (state_d == S_DONE) || (state_d == S_ERR);
    status_wdata_d = status_wdata_q;
    if (status_we_d) begin
      status_wdata_d = {16'(blk_idx_d), 13'b0, state_d == S_ERR,
                        state_d == S_DONE, state_d == S_RD_SRC};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      src_q          <= '0;
      blocks_q       <= '0;
      blk_idx_q      <= '0;
      word_idx_q     <= '0;
      abort_pend_q   <= 1'b0;
      word_q         <= '0;
      reg_req_q      <= 1'b0;
      reg_addr_q     <= '0;
      status_we_q    <= 1'b0;
      status_wdata_q <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      core_init_q    <= 1'b0;
      core_next_q    <= 1'b0;
      core_valid_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      blocks_q       <= blocks_d;
      blk_idx_q      <= blk_idx_d;
      word_idx_q     <= word_idx_d;
      abort_pend_q   <= abort_pend_d;
      word_q         <= word_d;
      reg_req_q      <= reg_req_d;
      reg_addr_q     <= reg_addr_d;
      status_we_q    <= status_we_d;
      status_wdata_q <= status_wdata_d;
      mem_req_q      <= mem_req_d;
      mem_addr_q     <= mem_addr_d;
      core_init_q    <= core_init_d;
      core_next_q    <= core_next_d;
      core_valid_q   <= core_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign reg_req_o      = reg_req_q;
  assign reg_addr_o     = reg_addr_q;
  assign status_we_o    = status_we_q;
  assign status_wdata_o = status_wdata_q;
  assign mem_req_o      = mem_req_q;
  assign mem_addr_o     = mem_addr_q;
  assign core_init_o    = core_init_q;
  assign core_next_o    = core_next_q;
  assign core_valid_o   = core_valid_q;
  assign core_word_o    = word_q;
  assign busy_o         = busy_q;

endmodule
